// File: rtl/vector_mac_sequencer.sv
// Operand-side sequencer for a lane-parallel vector MAC: issues operand pairs,
// feeds each MAC result back as the next addend and returns the accumulated vector.
module vector_mac_sequencer #(
    parameter int unsigned REG_WIDTH = 16,
    parameter int unsigned VECTOR    = 8,
    parameter int unsigned ACC_W     = 2 * REG_WIDTH,
    parameter int unsigned MAC_LAT   = 0,
    parameter int unsigned LEN_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic [LEN_W-1:0]     len_i,
    output logic                 busy_o,
    input  logic                 op_valid_i,
    output logic                 op_ready_o,
    input  logic [REG_WIDTH-1:0] op_a_i    [VECTOR],
    input  logic [REG_WIDTH-1:0] op_b_i    [VECTOR],
    output logic [REG_WIDTH-1:0] mac_a_o   [VECTOR],
    output logic [REG_WIDTH-1:0] mac_b_o   [VECTOR],
    output logic [ACC_W-1:0]     mac_c_o   [VECTOR],
    input  logic [ACC_W-1:0]     mac_res_i [VECTOR],
    output logic                 res_valid_o,
    input  logic                 res_ready_i,
    output logic [ACC_W-1:0]     res_data_o [VECTOR]
);

    localparam int unsigned CNT_W = (MAC_LAT > 1) ? $clog2(MAC_LAT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [LEN_W-1:0]     remain_q, remain_d;
    logic [CNT_W-1:0]     wait_q, wait_d;
    logic [ACC_W-1:0]     acc_q   [VECTOR];
    logic [ACC_W-1:0]     acc_d   [VECTOR];
    logic [REG_WIDTH-1:0] mac_a_q [VECTOR];
    logic [REG_WIDTH-1:0] mac_a_d [VECTOR];
    logic [REG_WIDTH-1:0] mac_b_q [VECTOR];
    logic [REG_WIDTH-1:0] mac_b_d [VECTOR];
    logic                 busy_q, op_ready_q, res_valid_q;

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        wait_d   = wait_q;
        acc_d    = acc_q;
        mac_a_d  = mac_a_q;
        mac_b_d  = mac_b_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    remain_d = len_i;
                    acc_d    = '{default: '0};
                    state_d  = (len_i != '0) ? ISSUE : DONE;
                end
            end
            ISSUE: begin
                if (op_valid_i) begin
                    mac_a_d  = op_a_i;
                    mac_b_d  = op_b_i;
                    remain_d = remain_q - LEN_W'(1);
                    wait_d   = CNT_W'(MAC_LAT);
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                // Operands and addend stay frozen until the MAC result is captured
                if (wait_q == '0) begin
                    acc_d   = mac_res_i;
                    state_d = (remain_q == '0) ? DONE : ISSUE;
                end else begin
                    wait_d = wait_q - CNT_W'(1);
                end
            end
            DONE: begin
                if (res_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; status flags decoded from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            remain_q    <= '0;
            wait_q      <= '0;
            acc_q       <= '{default: '0};
            mac_a_q     <= '{default: '0};
            mac_b_q     <= '{default: '0};
            busy_q      <= 1'b0;
            op_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            remain_q    <= remain_d;
            wait_q      <= wait_d;
            acc_q       <= acc_d;
            mac_a_q     <= mac_a_d;
            mac_b_q     <= mac_b_d;
            busy_q      <= (state_d != IDLE);
            op_ready_q  <= (state_d == ISSUE);
            res_valid_q <= (state_d == DONE);
        end
    end

    assign busy_o      = busy_q;
    assign op_ready_o  = op_ready_q;
    assign res_valid_o = res_valid_q;
    assign mac_a_o     = mac_a_q;
    assign mac_b_o     = mac_b_q;
    assign mac_c_o     = acc_q;
    assign res_data_o  = acc_q;

endmodule
